// File: rtl/mem_dumper_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_dumper_pkg : memory access size codes and dumper FSM state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_dumper_pkg;

  localparam logic [1:0] c_SIZE_BYTE = 2'b01;
  localparam logic [1:0] c_SIZE_HALF = 2'b10;
  localparam logic [1:0] c_SIZE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_dumper_word_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_dumper_word_serializer : loads a 32-bit word, shifts it out LSB byte first
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_dumper_word_serializer
  import mem_dumper_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_last_xfer
);

  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_valid;
  logic        w_xfer;

  assign w_xfer = r_valid & i_tx_ready;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      // Shifting in zeros leaves o_tx_data at 0 once the word is drained.
      r_shift <= {8'h00, r_shift[31:8]};
      r_idx   <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_tx_data   = r_shift[7:0];
  assign o_tx_valid  = r_valid;
  assign o_last_xfer = w_xfer & (r_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/mem_dumper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_dumper : reads consecutive memory words and streams them out as bytes
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_dumper
  import mem_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-2:0] i_word_count,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  output logic                  o_mem_ren,
  output logic [1:0]            o_mem_size,
  input  logic [31:0]           i_mem_dout,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-2:0] r_remaining;
  logic [ADDR_WIDTH-1:0] r_mem_raddr;
  logic                  r_mem_ren;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_load;
  logic                  w_last_xfer;
  logic [ADDR_WIDTH-1:0] w_base_aligned;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_base_aligned = i_base_addr & ~ADDR_WIDTH'(3);
  assign w_next_addr    = r_addr + ADDR_WIDTH'(4);

  // Read data is captured in READ for a combinational memory, in WAIT otherwise.
  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign w_load = (r_state == ST_READ);
    end else begin : g_lat1
      assign w_load = (r_state == ST_WAIT);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_mem_raddr <= '0;
      r_mem_ren   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_ren <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_busy      <= 1'b1;
            r_addr      <= w_base_aligned;
            r_remaining <= i_word_count;
            if (i_word_count == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_mem_ren   <= 1'b1;
              r_mem_raddr <= w_base_aligned;
            end
          end
        end
        ST_READ: r_state <= (READ_LATENCY == 0) ? ST_SEND : ST_WAIT;
        ST_WAIT: r_state <= ST_SEND;
        ST_SEND: begin
          if (w_last_xfer) begin
            r_addr      <= w_next_addr;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == (ADDR_WIDTH-1)'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_mem_ren   <= 1'b1;
              r_mem_raddr <= w_next_addr;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_dumper_word_serializer u_ser (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_word      (i_mem_dout),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_last_xfer (w_last_xfer)
  );

  assign o_mem_raddr = r_mem_raddr;
  assign o_mem_ren   = r_mem_ren;
  assign o_mem_size  = c_SIZE_WORD;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
`default_nettype wire
